// File: rtl/index_loader_pkg.sv
// rtl/index_loader_pkg.sv - shared widths, FSM encoding and byte positions for index_loader
package index_loader_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] B_I1 = 2'd0;
    localparam logic [1:0] B_I2 = 2'd1;
    localparam logic [1:0] B_D1 = 2'd2;
    localparam logic [1:0] B_D2 = 2'd3;

    // A load never exceeds the RAM depth, so the slot counter cannot wrap.
    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        return (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/index_loader_if.sv
// rtl/index_loader_if.sv - byte stream input and four-RAM write port of the loader
interface index_loader_if;
    import index_loader_pkg::*;

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    logic          wr_en;
    logic [AW-1:0] cnt1w;
    logic [AW-1:0] cnt2w;
    logic [AW-1:0] addr1w;
    logic [AW-1:0] addr2w;
    logic [DW-1:0] i1;
    logic [DW-1:0] i2;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output wr_en, cnt1w, cnt2w, addr1w, addr2w, i1, i2, din1, din2
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  wr_en, cnt1w, cnt2w, addr1w, addr2w, i1, i2, din1, din2
    );

endinterface

// File: rtl/index_loader_order_check.sv
// rtl/index_loader_order_check.sv - sticky strictly-increasing check on both index lists
module order_check
    import index_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          check,
    input  logic          first,
    input  logic [DW-1:0] i1,
    input  logic [DW-1:0] i2,
    output logic          err_order
);

    logic [DW-1:0] prev_i1;
    logic [DW-1:0] prev_i2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_i1   <= '0;
            prev_i2   <= '0;
            err_order <= 1'b0;
        end else if (clear) begin
            err_order <= 1'b0;
        end else if (check) begin
            // Slot 0 has no predecessor; it only seeds the previous values.
            if (!first && ((i1 <= prev_i1) || (i2 <= prev_i2)))
                err_order <= 1'b1;
            prev_i1 <= i1;
            prev_i2 <= i2;
        end
    end

endmodule

// File: rtl/index_loader.sv
// rtl/index_loader.sv - assembles 4-byte records and writes slot k of all four merge RAMs
module index_loader
    import index_loader_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [AW:0]    len,
    index_loader_if.master ifc,
    output logic           busy,
    output logic           load_done,
    output logic [AW:0]    entries,
    output logic           err_order
);

    state_t        state;
    logic [AW:0]   n;
    logic [AW-1:0] slot;
    logic [1:0]    byte_cnt;
    logic [DW-1:0] i1_q;
    logic [DW-1:0] i2_q;
    logic [DW-1:0] d1_q;
    logic [DW-1:0] d2_q;
    logic          start_ok;

    assign start_ok = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n        <= '0;
            slot     <= '0;
            byte_cnt <= B_I1;
            entries  <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n        <= clamp_len(len);
                        slot     <= '0;
                        byte_cnt <= B_I1;
                        entries  <= '0;
                        state    <= (clamp_len(len) == '0) ? DONE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (ifc.in_valid) begin
                        unique case (byte_cnt)
                            B_I1: i1_q <= ifc.in_data;
                            B_I2: i2_q <= ifc.in_data;
                            B_D1: d1_q <= ifc.in_data;
                            B_D2: d2_q <= ifc.in_data;
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == B_D2)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    entries <= entries + (AW+1)'(1);
                    if ({1'b0, slot} == n - (AW+1)'(1)) begin
                        state <= DONE;
                    end else begin
                        slot  <= slot + AW'(1);
                        state <= COLLECT;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register; addresses and data
    // simply hold while idle so the engine can ignore them.
    assign ifc.in_ready = (state == COLLECT);
    assign ifc.wr_en    = (state == WRITE);
    assign ifc.cnt1w    = slot;
    assign ifc.cnt2w    = slot;
    assign ifc.addr1w   = slot;
    assign ifc.addr2w   = slot;
    assign ifc.i1       = i1_q;
    assign ifc.i2       = i2_q;
    assign ifc.din1     = d1_q;
    assign ifc.din2     = d2_q;
    assign busy         = (state != IDLE);
    assign load_done    = (state == DONE);

    order_check u_order_check (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .check     (state == WRITE),
        .first     (slot == '0),
        .i1        (i1_q),
        .i2        (i2_q),
        .err_order (err_order)
    );

endmodule

// File: tb/tb_index_loader.sv
// tb/tb_index_loader.sv - self-checking bench for index_loader
module tb_index_loader;
    import index_loader_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          load_done;
    logic [AW:0]   entries;
    logic          err_order;

    index_loader_if ifc ();

    index_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .ifc       (ifc),
        .busy      (busy),
        .load_done (load_done),
        .entries   (entries),
        .err_order (err_order)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       slot;
        logic [7:0] i1;
        logic [7:0] i2;
        logic [7:0] d1;
        logic [7:0] d2;
    } rec_t;

    int   checks = 0;
    int   errors = 0;
    rec_t stim[$];
    rec_t exp_q[$];
    logic model_err = 1'b0;
    logic [7:0] prev_i1, prev_i2;
    bit   have_prev = 0;
    int   exp_entries = 0;
    int   done_count = 0;
    int   write_count = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each write must be the next expected record at its slot;
    // the order flag follows the records actually written so far.
    always @(negedge clk) begin
        if (reset) begin
            rec_t r;
            check("err_order_track", err_order, model_err);
            if (ifc.wr_en) begin
                write_count++;
                check("in_ready_in_write", ifc.in_ready, 0);
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    check("cnt1w", ifc.cnt1w, r.slot);
                    check("cnt2w", ifc.cnt2w, r.slot);
                    check("addr1w", ifc.addr1w, r.slot);
                    check("addr2w", ifc.addr2w, r.slot);
                    check("i1", ifc.i1, r.i1);
                    check("i2", ifc.i2, r.i2);
                    check("din1", ifc.din1, r.d1);
                    check("din2", ifc.din2, r.d2);
                    if (have_prev && (r.i1 <= prev_i1 || r.i2 <= prev_i2))
                        model_err = 1'b1;
                    prev_i1 = r.i1;
                    prev_i2 = r.i2;
                    have_prev = 1;
                end
            end
            if (load_done) begin
                done_count++;
                check("entries_at_done", entries, exp_entries);
                check("writes_left_at_done", exp_q.size(), 0);
            end
        end
    end

    task automatic set_rec(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        rec_t r;
        r.slot = k; r.i1 = a; r.i2 = b; r.d1 = c; r.d2 = d;
        stim.push_back(r);
    endtask

    task automatic pulse_start(input int l);
        len = (AW+1)'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                ifc.in_valid = 1'b0;
                ifc.in_data  = 8'hEE;
                @(posedge clk); #1;
            end
        end
        ifc.in_data  = b;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_rec(input int k, input bit gaps);
        send_byte(stim[k].i1, gaps);
        send_byte(stim[k].i2, gaps);
        send_byte(stim[k].d1, gaps);
        send_byte(stim[k].d2, gaps);
    endtask

    task automatic expect_load(input int l);
        int n = (l > DEPTH) ? DEPTH : l;
        for (int k = 0; k < n; k++) exp_q.push_back(stim[k]);
        exp_entries = n;
    endtask

    task automatic wait_done(input int d0);
        int g = 0;
        while (done_count == d0 && g < 200) begin
            @(negedge clk); #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("load_done_pulses", done_count - d0, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic run_load(input int l, input bit gaps);
        int d0 = done_count;
        int n = (l > DEPTH) ? DEPTH : l;
        expect_load(l);
        pulse_start(l);
        model_err = 1'b0;
        have_prev = 0;
        for (int k = 0; k < n; k++) send_rec(k, gaps);
        ifc.in_valid = 1'b0;
        wait_done(d0);
    endtask

    task automatic basic_stim();
        stim.delete();
        set_rec(0, 8'h01, 8'h02, 8'hA0, 8'hB0);
        set_rec(1, 8'h03, 8'h05, 8'hA1, 8'hB1);
    endtask

    initial begin
        int w0, d0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        ifc.in_data  = '0;
        ifc.in_valid = 1'b0;
        #1;
        check("rst_wr_en", ifc.wr_en, 0);
        check("rst_in_ready", ifc.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_entries", entries, 0);
        check("rst_err_order", err_order, 0);
        check("rst_cnt1w", ifc.cnt1w, 0);
        check("rst_i1", ifc.i1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        basic_stim();
        w0 = write_count;
        run_load(2, 0);
        check("basic_entries", entries, 2);
        check("basic_err", err_order, 0);
        check("basic_writes", write_count - w0, 2);

        w0 = write_count;
        run_load(2, 1);
        check("gaps_writes", write_count - w0, 2);
        check("gaps_entries", entries, 2);

        stim.delete();
        set_rec(0, 8'h05, 8'h10, 8'hC0, 8'hD0);
        set_rec(1, 8'h04, 8'h11, 8'hC1, 8'hD1);
        set_rec(2, 8'h06, 8'h12, 8'hC2, 8'hD2);
        w0 = write_count;
        run_load(3, 0);
        check("order_err_set", err_order, 1);
        check("order_writes", write_count - w0, 3);
        check("order_entries", entries, 3);

        w0 = write_count;
        d0 = done_count;
        exp_entries = 0;
        pulse_start(0);
        model_err = 1'b0;
        have_prev = 0;
        check("len0_done_latency", load_done, 1);
        check("len0_err_cleared", err_order, 0);
        wait_done(d0);
        check("len0_no_writes", write_count - w0, 0);

        stim.delete();
        for (int k = 0; k < DEPTH; k++)
            set_rec(k, 8'(k * 3 + 1), 8'(k * 2 + 7), 8'(8'h40 + k), 8'(8'h80 + k));
        w0 = write_count;
        run_load(20, 0);
        check("clamp_entries", entries, 16);
        check("clamp_writes", write_count - w0, 16);
        check("clamp_err", err_order, 0);

        stim.delete();
        set_rec(0, 8'h10, 8'h20, 8'h31, 8'h41);
        set_rec(1, 8'h11, 8'h21, 8'h32, 8'h42);
        set_rec(2, 8'h12, 8'h22, 8'h33, 8'h43);
        w0 = write_count;
        d0 = done_count;
        expect_load(3);
        pulse_start(3);
        model_err = 1'b0;
        have_prev = 0;
        send_rec(0, 0);
        send_byte(stim[1].i1, 0);
        send_byte(stim[1].i2, 0);
        ifc.in_valid = 1'b0;
        pulse_start(1);
        send_byte(stim[1].d1, 0);
        send_byte(stim[1].d2, 0);
        send_rec(2, 0);
        ifc.in_valid = 1'b0;
        wait_done(d0);
        check("busy_start_entries", entries, 3);
        check("busy_start_writes", write_count - w0, 3);

        basic_stim();
        w0 = write_count;
        exp_q.delete();
        exp_q.push_back(stim[0]);
        exp_entries = 2;
        pulse_start(2);
        model_err = 1'b0;
        have_prev = 0;
        send_rec(0, 0);
        send_byte(stim[1].i1, 0);
        send_byte(stim[1].i2, 0);
        ifc.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_wr_en", ifc.wr_en, 0);
        check("mid_rst_in_ready", ifc.in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_entries", entries, 0);
        check("mid_rst_addr2w", ifc.addr2w, 0);
        check("mid_rst_din2", ifc.din2, 0);
        check("mid_rst_slot0_written", write_count - w0, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_no_write", write_count - w0, 1);
        w0 = write_count;
        run_load(2, 0);
        check("post_rst_writes", write_count - w0, 2);
        check("post_rst_entries", entries, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/index_loader.md
Name: index_loader

Overview:
- Upstream fill stage for the dual index/data memory merge engine.
- Accepts a byte stream of records. Each record is index1, index2, data1, data2.
- Assembles each record and drives the engine's shared write port: wr_en, cnt1w/cnt2w, i1/i2, addr1w/addr2w, din1/din2. It writes slot k of all four RAMs in one cycle.
- Signals load_done so the engine can start comparing with wr_en low.

Parameters:
- DW, 8, data/index byte width.
- AW, 4, slot address width.
- DEPTH, 16, number of slots (2**AW).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load of len records.
- len  input  AW+1  record count, sampled on start.
- in_data  input  DW  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  write strobe shared by all four RAMs.
- cnt1w  output  AW  index memory 1 write address.
- cnt2w  output  AW  index memory 2 write address.
- addr1w  output  AW  data memory 1 write address.
- addr2w  output  AW  data memory 2 write address.
- i1  output  DW  index1 write data.
- i2  output  DW  index2 write data.
- din1  output  DW  data1 write data.
- din2  output  DW  data2 write data.
- busy  output  1  load in progress.
- load_done  output  1  one-cycle pulse at end of load.
- entries  output  AW+1  number of records written in the last load.
- err_order  output  1  sticky flag; set if an index list is not strictly increasing.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0 and the FSM goes to IDLE. The same applies mid-load. No partial write completes, and the RAM contents already written are left as-is.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start=1 latches n = min(len, DEPTH), clears slot, byte_cnt, err_order and entries, and sets busy=1.
  - If n=0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - in_ready=1.
  - A byte is accepted when in_valid and in_ready are both 1.
  - Bytes are registered by byte_cnt: 0 to i1, 1 to i2, 2 to din1, 3 to din2.
  - When the 4th byte is accepted, go to WRITE. No bubble between bytes is required.
- WRITE (exactly one cycle):
  - in_ready=0, wr_en=1.
  - cnt1w = cnt2w = addr1w = addr2w = slot. i1/i2/din1/din2 are stable from the registers.
  - Order check, for slot>0 only: set err_order if i1 <= prev_i1 or i2 <= prev_i2 (unsigned). Then store prev_i1/prev_i2.
  - entries increments.
  - If slot == n-1, go to DONE; otherwise slot increments and the FSM returns to COLLECT.
- DONE (one cycle): load_done=1, busy=0 from the next cycle, then go to IDLE.
- wr_en is 0 in every state except WRITE. Address and data outputs hold their last values in IDLE, so the engine sees wr_en=0 and uses its own read addresses.
- Latency: 4th byte accepted in cycle t, wr_en=1 in t+1, in_ready=1 again in t+2. After the final record, load_done is asserted in t+2.
- start while busy=1: ignored.
- in_valid while in_ready=0: byte not consumed; the source holds it.
- Slot counter never wraps within a load because n <= DEPTH. len > DEPTH is clamped to DEPTH, and entries reports DEPTH.
- err_order does not stop the load. It holds until the next accepted start or reset.

Decomposition:
- Shared package: DW, AW, DEPTH, the FSM state encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3), and byte-position constants (B_I1=0, B_I2=1, B_D1=2, B_D2=3).
- One sub-module: order_check. It holds registered prev_i1/prev_i2 and computes the sticky err_order. Inputs: check strobe, first-slot flag, i1, i2, clear.

Test Plan:
- Basic load: start, len=2, stream 01,02,A0,B0,03,05,A1,B1 with in_valid held at 1. Required: wr_en pulses with slot 0 (i1=01,i2=02,din1=A0,din2=B0) and slot 1 (03,05,A1,B1); load_done once; entries=2; err_order=0.
- Back-pressure and gaps: same stream with in_valid toggled randomly. Required: identical writes; in_ready=0 in every WRITE cycle; no byte lost or duplicated.
- Order error: len=3, index1 sequence 05,04,06. Required: err_order=1 after slot 1's write; all 3 slots still written; flag cleared by the next start.
- Boundaries: len=0 gives load_done one cycle after start with no wr_en. len=20 gives 16 writes, slots 0..15, and entries=16.
- Start while busy: a second start mid-load with len=1. Required: ignored; the original len=3 completes.
- Reset mid-operation: drive reset=0 between byte 2 and byte 3 of slot 1. Required: all outputs 0 immediately (asynchronous); no slot-1 write; after release, a fresh start loads correctly from slot 0.
